// File: rtl/sumaresta_if.sv
// Operation/result bus for the sumaresta accumulator: request side (A, Q, valid/ready)
// and result side (D, C, Z, valid/ready).
interface sumaresta_if #(
  parameter int WIDTH = 4
);
  logic [1:0]       A;
  logic [WIDTH-1:0] Q;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] D;
  logic             C;
  logic             Z;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output A, Q, in_valid, out_ready,
    input  in_ready, D, C, Z, out_valid
  );

  modport slave (
    input  A, Q, in_valid, out_ready,
    output in_ready, D, C, Z, out_valid
  );
endinterface

// File: rtl/sumaresta_acc.sv
// WIDTH-bit LOAD/SUMA/RESTA/CLEAR accumulator with valid/ready handshakes on both sides.
// Define SUMARESTA_SAT_EN to make SUMA/RESTA saturate instead of wrapping.
module sumaresta_acc #(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic        clk,
  input  logic        rst,
  sumaresta_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_LOAD  = 2'd0;
  localparam logic [1:0] OP_SUMA  = 2'd1;
  localparam logic [1:0] OP_RESTA = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  state_t           state_q, state_d;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             c_q, c_d;
  logic             z_q, z_d;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;

  // The top bit of each extended result is the carry (SUMA) or borrow (RESTA).
  function automatic logic [WIDTH-1:0] fit_sum(input logic [WIDTH:0] s);
`ifdef SUMARESTA_SAT_EN
    fit_sum = s[WIDTH] ? {WIDTH{1'b1}} : s[WIDTH-1:0];
`else
    fit_sum = s[WIDTH-1:0];
`endif
  endfunction

  function automatic logic [WIDTH-1:0] fit_diff(input logic [WIDTH:0] d);
`ifdef SUMARESTA_SAT_EN
    fit_diff = d[WIDTH] ? {WIDTH{1'b0}} : d[WIDTH-1:0];
`else
    fit_diff = d[WIDTH-1:0];
`endif
  endfunction

  // Operand capture happens only on the IDLE accept cycle, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && bus.in_valid) begin
      op_q   <= bus.A;
      opnd_q <= bus.Q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= ACC_INIT;
      c_q     <= 1'b0;
      z_q     <= (ACC_INIT == '0);
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      z_q     <= z_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    c_d      = c_q;
    z_d      = z_q;
    sum_ext  = {1'b0, acc_q} + {1'b0, opnd_q};
    diff_ext = {1'b0, acc_q} - {1'b0, opnd_q};
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) state_d = EXEC;
      end
      EXEC: begin
        state_d = DONE;
        unique case (op_q)
          OP_LOAD: begin
            acc_d = opnd_q;
            c_d   = 1'b0;
          end
          OP_SUMA: begin
            acc_d = fit_sum(sum_ext);
            c_d   = sum_ext[WIDTH];
          end
          OP_RESTA: begin
            acc_d = fit_diff(diff_ext);
            c_d   = diff_ext[WIDTH];
          end
          OP_CLEAR: begin
            acc_d = ACC_INIT;
            c_d   = 1'b0;
          end
          default: begin
            acc_d = acc_q;
            c_d   = c_q;
          end
        endcase
        z_d = (acc_d == '0);
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.D         = acc_q;
  assign bus.C         = c_q;
  assign bus.Z         = z_q;

endmodule

// File: tb/tb_sumaresta_acc.sv
// Scoreboard bench for sumaresta_acc (WIDTH=4, ACC_INIT=0): directed operations push
// expected results; a negedge monitor pops and compares on every output handshake.
module tb_sumaresta_acc;
  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] d;
    logic         c;
    logic         z;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sumaresta_if #(.WIDTH(W)) bus ();

  sumaresta_acc #(.WIDTH(W), .ACC_INIT(4'd0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  res_t exp_q[$];
  res_t mon_e;
  int   errors = 0;
  int   checks = 0;
  time  acc_time;
  time  last_acc;
  logic [W-1:0] model_acc;
  logic [W-1:0] model_nxt;
  logic         model_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("res_D", bus.D, mon_e.d);
        check("res_C", bus.C, mon_e.c);
        check("res_Z", bus.Z, mon_e.z);
      end
    end
  end

  task automatic op(input logic [1:0] a, input logic [W-1:0] q,
                    input logic [W-1:0] ed, input logic ec, input logic ez,
                    input bit chk_lat);
    int guard = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) check("in_ready_timeout", 0, 1);
    exp_q.push_back(res_t'{d: ed, c: ec, z: ez});
    bus.A        = a;
    bus.Q        = q;
    bus.in_valid = 1'b1;
    @(posedge clk);
    acc_time = $time;
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (chk_lat) check("lat_exec_ov", bus.out_valid, 0);
    @(negedge clk);
    if (chk_lat) check("lat_done_ov", bus.out_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.A         = 2'd0;
    bus.Q         = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_D", bus.D, 0);
    check("rst_C", bus.C, 0);
    check("rst_Z", bus.Z, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    rst = 1'b0;

    // Reset arriving mid-EXEC discards the LOAD 9 and forces outputs at once.
    op(2'd0, 4'd5, 4'd5, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    bus.A = 2'd0; bus.Q = 4'd9; bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("abort_D", bus.D, 0);
    check("abort_C", bus.C, 0);
    check("abort_Z", bus.Z, 1);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_D_hold", bus.D, 0);

    // LOAD 9 then SUMA 9.
    op(2'd0, 4'd9, 4'd9, 1'b0, 1'b0, 1'b1);
`ifdef SUMARESTA_SAT_EN
    op(2'd1, 4'd9, 4'd15, 1'b1, 1'b0, 1'b1);
`else
    op(2'd1, 4'd9, 4'd2, 1'b1, 1'b0, 1'b1);
`endif

    // LOAD 3 then RESTA 5; then RESTA 0 from 14.
    op(2'd0, 4'd3, 4'd3, 1'b0, 1'b0, 1'b1);
`ifdef SUMARESTA_SAT_EN
    op(2'd2, 4'd5, 4'd0, 1'b1, 1'b1, 1'b1);
`else
    op(2'd2, 4'd5, 4'd14, 1'b1, 1'b0, 1'b1);
`endif
    op(2'd0, 4'd14, 4'd14, 1'b0, 1'b0, 1'b1);
    op(2'd2, 4'd0, 4'd14, 1'b0, 1'b0, 1'b1);

    // Backpressure on a SUMA result of 7 while a CLEAR is pending.
    op(2'd0, 4'd3, 4'd3, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    op(2'd1, 4'd4, 4'd7, 1'b0, 1'b0, 1'b1);
    exp_q.push_back(res_t'{d: 4'd0, c: 1'b0, z: 1'b1});
    bus.A = 2'd3; bus.Q = 4'd0; bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_D", bus.D, 7);
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_in_ready", bus.in_ready, 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_ov", bus.out_valid, 0);
    check("bp_release_ir", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp_clear_accepted", bus.in_ready, 0);
    repeat (3) @(negedge clk);

    // RESTA sweep Q=0..15 starting from 15, back to back.
    op(2'd0, 4'd15, 4'd15, 1'b0, 1'b0, 1'b1);
    model_acc = 4'd15;
    for (int q = 0; q < 16; q++) begin
      model_b   = (q > model_acc);
      model_nxt = model_acc - 4'(q);
`ifdef SUMARESTA_SAT_EN
      if (model_b) model_nxt = 4'd0;
`endif
      op(2'd2, 4'(q), model_nxt, model_b, (model_nxt == 4'd0), 1'b1);
      if (q > 0) check("accept_spacing", 32'(acc_time - last_acc), 30);
      last_acc  = acc_time;
      model_acc = model_nxt;
    end

    // CLEAR ignores Q.
    op(2'd3, 4'd11, 4'd0, 1'b0, 1'b1, 1'b1);

    for (int g = 0; g < 20 && exp_q.size() != 0; g++) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
